// File: rtl/ahb_timer_pkg.sv
// Shared constants for the AHB-Lite down-counting timer: register offsets,
// CTRL/STATUS bit positions, HTRANS encodings and the register-select enum.
package ahb_timer_pkg;

  localparam logic [3:0] OFF_LOAD   = 4'h0;
  localparam logic [3:0] OFF_VALUE  = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_PS_LSB  = 4;
  localparam int CTRL_PS_MSB  = 11;
  localparam int STATUS_IRQ   = 0;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_VALUE  = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_STATUS = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/ahb_timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale+1) clocks while en=1.
// Cleared whenever en is low or clr is pulsed.
module ahb_timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    tick  = en && (cnt_q == prescale);
    cnt_d = cnt_q + 8'd1;
    if (!en || clr || tick) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite zero-wait-state timer slave: 32-bit down counter with reload,
// one-shot/periodic modes and a level interrupt. Optional macro TIMER_PRESCALE_EN.
module ahb_timer
  import ahb_timer_pkg::*;
#(
  parameter int ADDR_LSB_W = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        timer_irq
);

  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  reg_sel_e   sel_q, sel_d;

  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        oneshot_q, oneshot_d;
  logic        status_q, status_d;
  logic [7:0]  prescale_q;

  logic accept, load_wr, ctrl_wr, status_wr;
  logic tick, tick_eff, expire;
  logic unused_ok;

  assign unused_ok = ^{HSIZE, HADDR, HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign timer_irq = status_q & irq_en_q;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale_d;

  always_comb begin
    prescale_d = prescale_q;
    if (ctrl_wr) prescale_d = HWDATA[CTRL_PS_MSB:CTRL_PS_LSB];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) prescale_q <= 8'd0;
    else          prescale_q <= prescale_d;
  end

  ahb_timer_prescaler u_prescaler (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .en       (en_q),
    .clr      (ctrl_wr | load_wr),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign prescale_q = 8'd0;
  assign tick       = en_q;
`endif

  // Address phase capture; the enables drop whenever no transfer is accepted
  always_comb begin
    accept  = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    wr_en_d = accept && HWRITE;
    rd_en_d = accept && !HWRITE;
    sel_d   = accept ? reg_sel_e'(HADDR[ADDR_LSB_W-1 -: 2]) : sel_q;
  end

  // Data phase: register updates and counting
  always_comb begin
    load_wr   = wr_en_q && (sel_q == SEL_LOAD);
    ctrl_wr   = wr_en_q && (sel_q == SEL_CTRL);
    status_wr = wr_en_q && (sel_q == SEL_STATUS);
    // Software disabling the timer on this edge swallows any tick in flight
    tick_eff  = tick && !(ctrl_wr && !HWDATA[CTRL_EN]);
    expire    = tick_eff && (value_q == 32'd0);

    load_d    = load_q;
    value_d   = value_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    oneshot_d = oneshot_q;
    status_d  = status_q;

    if (load_wr) load_d = HWDATA;

    if (load_wr)
      value_d = HWDATA;
    else if (tick_eff)
      value_d = (value_q != 32'd0) ? value_q - 32'd1 : (oneshot_q ? 32'd0 : load_q);

    if (expire && oneshot_q) en_d = 1'b0;
    if (ctrl_wr) begin
      en_d      = HWDATA[CTRL_EN];
      irq_en_d  = HWDATA[CTRL_IRQ_EN];
      oneshot_d = HWDATA[CTRL_ONESHOT];
    end

    if (status_wr && HWDATA[STATUS_IRQ]) status_d = 1'b0;
    if (expire) status_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      sel_q     <= SEL_LOAD;
      load_q    <= 32'd0;
      value_q   <= 32'd0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      oneshot_q <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      value_q   <= value_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      oneshot_q <= oneshot_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_en_q) begin
      unique case (sel_q)
        SEL_LOAD:   HRDATA = load_q;
        SEL_VALUE:  HRDATA = value_q;
        SEL_CTRL:   HRDATA = {20'd0, prescale_q, 1'b0, oneshot_q, irq_en_q, en_q};
        SEL_STATUS: HRDATA = {31'd0, status_q};
        default:    HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_timer.sv
// Scoreboard bench for ahb_timer: directed scenarios plus random bus traffic,
// checked against a register-level behavioural model of the timer.
module tb_ahb_timer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        timer_irq;

  ahb_timer #(.ADDR_LSB_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .timer_irq(timer_irq)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_load, m_value;
  logic        m_en, m_irq_en, m_oneshot, m_flag;
  logic [7:0]  m_ps;
  int          m_since_tick;

  // Bench-side view of the pending data phase
  logic        dp_wr, dp_rd;
  logic [1:0]  dp_idx;
  logic [31:0] dp_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return m_load;
      2'd1:    return m_value;
`ifdef TIMER_PRESCALE_EN
      2'd2:    return {20'd0, m_ps, 1'b0, m_oneshot, m_irq_en, m_en};
`else
      2'd2:    return {29'd0, m_oneshot, m_irq_en, m_en};
`endif
      default: return {31'd0, m_flag};
    endcase
  endfunction

  task automatic model_reset();
    m_load = 0; m_value = 0; m_en = 0; m_irq_en = 0; m_oneshot = 0;
    m_flag = 0; m_ps = 0; m_since_tick = 0;
    dp_wr = 0; dp_rd = 0; dp_idx = 0; dp_wdata = 0;
  endtask

  // One clock edge of the timer's rules, applied to the data phase in flight
  task automatic model_step(input logic wr, input logic [1:0] idx, input logic [31:0] wd);
    logic tick, expire, load_wr, ctrl_wr, stat_wr, prev_en;
    load_wr = wr && idx == 2'd0;
    ctrl_wr = wr && idx == 2'd2;
    stat_wr = wr && idx == 2'd3;
    prev_en = m_en;
`ifdef TIMER_PRESCALE_EN
    // m_since_tick = HCLK cycles elapsed since the prescale period restarted
    tick = m_en && (m_since_tick == int'(m_ps));
`else
    tick = m_en;
`endif
    if (ctrl_wr && !wd[0]) tick = 1'b0;
    expire = tick && m_value == 0;
    if (load_wr) m_value = wd;
    else if (tick) m_value = (m_value != 0) ? m_value - 1 : (m_oneshot ? 32'd0 : m_load);
    if (load_wr) m_load = wd;
    if (expire) m_flag = 1'b1;
    else if (stat_wr && wd[0]) m_flag = 1'b0;
    if (ctrl_wr) begin
      m_en = wd[0]; m_irq_en = wd[1]; m_oneshot = wd[2]; m_ps = wd[11:4];
    end else if (expire && m_oneshot) begin
      m_en = 1'b0;
    end
    if (!prev_en || ctrl_wr || load_wr || (prev_en && m_since_tick == int'(m_ps)))
      m_since_tick = 0;
    else
      m_since_tick++;
  endtask

  // One bus cycle: drive address phase (and data for the previous phase), predict, clock
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [1:0] idx, input logic rdy, input logic [31:0] wd);
    logic acc;
    exp_t e;
    HWDATA = dp_wdata;
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = $urandom();
    HADDR[3:2] = idx;
    HSIZE  = 3'($urandom_range(0, 7));
    HREADY = rdy;
    e.rd    = dp_rd;
    e.rdata = dp_rd ? model_read(dp_idx) : 32'd0;
    e.irq   = m_flag & m_irq_en;
    exp_q.push_back(e);
    @(posedge HCLK);
    model_step(dp_wr, dp_idx, dp_wdata);
    acc = sel && rdy && tr[1];
    dp_wr = acc && wr;
    dp_rd = acc && !wr;
    if (acc) dp_idx = idx;
    dp_wdata = wd;
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d);
    cyc(1'b1, 2'b10, 1'b1, idx, 1'b1, d);
  endtask

  task automatic rd_reg(input logic [1:0] idx);
    cyc(1'b1, 2'b10, 1'b0, idx, 1'b1, 32'd0);
  endtask

  // Monitor: compare the DUT's data-phase outputs with the oldest prediction
  always @(negedge HCLK) begin
    if (HRESETn && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.rd ? "hrdata_read" : "hrdata_idle", HRDATA, e.rdata);
      check("timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
      check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    end
  end

  initial begin
    HRESETn = 1'b0;
    HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 3'd2; HWDATA = 0; HREADY = 1;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    for (int i = 0; i < 4; i++) rd_reg(2'(i));

    // Periodic, LOAD=3
    wr_reg(2'd0, 32'd3);
    wr_reg(2'd2, 32'h3);
    repeat (10) rd_reg(2'd1);
    rd_reg(2'd3);

    // STATUS clears every cycle; some coincide with expiry
    repeat (8) wr_reg(2'd3, 32'd1);
    rd_reg(2'd3);
    wr_reg(2'd2, 32'h2);
    wr_reg(2'd3, 32'd1);
    rd_reg(2'd3);
    wr_reg(2'd3, 32'd0);
    rd_reg(2'd3);

    // One-shot, LOAD=5
    wr_reg(2'd0, 32'd5);
    wr_reg(2'd2, 32'h7);
    repeat (9) rd_reg(2'd1);
    rd_reg(2'd2);
    rd_reg(2'd3);
    rd_reg(2'd1);

    // Bus protocol corner cases
    cyc(1'b1, 2'b00, 1'b1, 2'd0, 1'b1, 32'h11);
    cyc(1'b1, 2'b01, 1'b1, 2'd0, 1'b1, 32'h22);
    cyc(1'b0, 2'b10, 1'b1, 2'd0, 1'b1, 32'h33);
    cyc(1'b1, 2'b10, 1'b1, 2'd0, 1'b0, 32'h44);
    rd_reg(2'd0);
    wr_reg(2'd0, 32'hA5);
    rd_reg(2'd0);
    wr_reg(2'd1, 32'h1234);
    rd_reg(2'd1);
    cyc(1'b1, 2'b11, 1'b0, 2'd0, 1'b1, 32'd0);

    // Prescale 3 (only divides when the macro is defined)
    wr_reg(2'd2, 32'h0);
    wr_reg(2'd0, 32'd1);
    wr_reg(2'd2, 32'h33);
    repeat (20) rd_reg(2'd1);
    rd_reg(2'd3);

    // Asynchronous reset mid-count
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    #1;
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    model_reset();
    HSEL = 0; HTRANS = 0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) rd_reg(2'(i));
    repeat (3) rd_reg(2'd1);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  idx;
      logic [31:0] d;
      idx = 2'($urandom_range(0, 3));
      case (idx)
        2'd0:    d = $urandom_range(0, 6);
        2'd2:    d = ($urandom() & 32'hFFFF_F0F7 & 32'h0000_0037) | 32'(($urandom_range(0, 9) != 0));
        2'd3:    d = $urandom();
        default: d = $urandom();
      endcase
      cyc(($urandom_range(0, 7) != 0), 2'($urandom()), ($urandom_range(0, 3) == 0),
          idx, ($urandom_range(0, 4) != 0), d);
    end

    repeat (3) rd_reg(2'd3);
    @(negedge HCLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
